// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: shift-add-3, one input bit per clock,
// start/done handshake, optional two's-complement input, overflow flag.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf
);

  localparam int unsigned AW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] mag_in;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_adj;
  logic [AW-1:0]    acc_nxt;
  logic [CW-1:0]    cnt;
  logic             neg_r;
  logic             ovf_r;
  logic             ovf_nxt;
  logic             in_neg;

  // Input magnitude; unsigned negate keeps -2^(WIDTH-1) exact.
  always_comb begin
    in_neg = SIGNED & bin[WIDTH-1];
    mag_in = in_neg ? ((~bin) + WIDTH'(1)) : bin;
  end

  // Add-3 correction on every digit, then the one-bit shift of {acc,mag}.
  always_comb begin
    acc_adj = acc;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
    acc_nxt = {acc_adj[AW-2:0], mag[WIDTH-1]};
    // The bit leaving the top digit is a carry worth 10^DIGITS.
    ovf_nxt = ovf_r | acc_adj[AW-1];
  end

  // Control FSM and datapath registers; results published only on done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mag   <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg_r <= 1'b0;
      ovf_r <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag   <= mag_in;
            neg_r <= in_neg;
            acc   <= '0;
            ovf_r <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= acc_nxt;
          mag   <= {mag[WIDTH-2:0], 1'b0};
          ovf_r <= ovf_nxt;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            bcd   <= acc_nxt;
            neg   <= neg_r;
            ovf   <= ovf_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: five configurations share one stimulus
// stream; accepted requests push expectations, a monitor pops on done.
module tb_bin2bcd_seq;

  localparam int unsigned W = 16;

  logic clk;
  logic rst_n;
  logic start;
  logic [W-1:0] bin;

  logic        busy0, busy1, busy2, busy3, busy4;
  logic        done0, done1, done2, done3, done4;
  logic        neg0, neg1, neg2, neg3, neg4;
  logic        ovf0, ovf1, ovf2, ovf3, ovf4;
  logic [19:0] bcd0, bcd1;
  logic [15:0] bcd2;
  logic [11:0] bcd3, bcd4;

  logic        busy_o [5];
  logic        done_o [5];
  logic        neg_o  [5];
  logic        ovf_o  [5];
  logic [39:0] bcd_o  [5];

  // Configurations: {digits, signed}
  int dg [5] = '{5, 5, 4, 3, 3};
  bit sg [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy0), .done(done0), .bcd(bcd0), .neg(neg0), .ovf(ovf0));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy1), .done(done1), .bcd(bcd1), .neg(neg1), .ovf(ovf1));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(4), .SIGNED(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy2), .done(done2), .bcd(bcd2), .neg(neg2), .ovf(ovf2));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(3), .SIGNED(1'b1)) u3 (.clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy3), .done(done3), .bcd(bcd3), .neg(neg3), .ovf(ovf3));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(3), .SIGNED(1'b0)) u4 (.clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy4), .done(done4), .bcd(bcd4), .neg(neg4), .ovf(ovf4));

  assign busy_o[0] = busy0; assign busy_o[1] = busy1; assign busy_o[2] = busy2;
  assign busy_o[3] = busy3; assign busy_o[4] = busy4;
  assign done_o[0] = done0; assign done_o[1] = done1; assign done_o[2] = done2;
  assign done_o[3] = done3; assign done_o[4] = done4;
  assign neg_o[0] = neg0; assign neg_o[1] = neg1; assign neg_o[2] = neg2;
  assign neg_o[3] = neg3; assign neg_o[4] = neg4;
  assign ovf_o[0] = ovf0; assign ovf_o[1] = ovf1; assign ovf_o[2] = ovf2;
  assign ovf_o[3] = ovf3; assign ovf_o[4] = ovf4;
  assign bcd_o[0] = 40'(bcd0); assign bcd_o[1] = 40'(bcd1); assign bcd_o[2] = 40'(bcd2);
  assign bcd_o[3] = 40'(bcd3); assign bcd_o[4] = 40'(bcd4);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected entry per DUT: {ovf, neg, bcd[39:0]}
  typedef logic [4:0][41:0] exp5_t;

  exp5_t exp_q[$];
  exp5_t held;
  exp5_t hand_exp;
  logic  hand_valid;

  int n_cmp = 0;
  int n_bad = 0;

  logic m_busy;
  logic m_done;
  int   m_cnt;

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, idx, $time, act, expv);
    end
  endtask

  function automatic logic [41:0] mk(input bit o, input bit n, input logic [39:0] b);
    return {o, n, b};
  endfunction

  function automatic exp5_t pack5(input logic [41:0] e0, input logic [41:0] e1, input logic [41:0] e2,
                                  input logic [41:0] e3, input logic [41:0] e4);
    exp5_t r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3; r[4] = e4;
    return r;
  endfunction

  // Reference model: decimal arithmetic on the magnitude.
  function automatic logic [41:0] ref_conv(input logic [W-1:0] b, input int digits, input bit sgn);
    longint m;
    longint lim;
    logic [39:0] r;
    bit n;
    bit o;
    r = '0;
    n = sgn && b[W-1];
    m = n ? (longint'(65536) - longint'(b)) : longint'(b);
    lim = 1;
    for (int d = 0; d < digits; d++) lim = lim * 10;
    o = (m >= lim);
    m = m % lim;
    for (int d = 0; d < digits; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {o, n, r};
  endfunction

  function automatic exp5_t ref_all(input logic [W-1:0] b);
    exp5_t r;
    for (int i = 0; i < 5; i++) r[i] = ref_conv(b, dg[i], sg[i]);
    return r;
  endfunction

  // Acceptance/timing model: pushes an expectation on each accepted start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt  = 0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == W) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (start) begin
        if (hand_valid) exp_q.push_back(hand_exp);
        else            exp_q.push_back(ref_all(bin));
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
  end

  // Monitor: pops on done, checks handshake and held results every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = '0;
    end else if (done_o[0]) begin
      if (exp_q.size() == 0) begin
        chk("done_without_request", 0, 64'(done_o[0]), 64'(0));
      end else begin
        held = exp_q.pop_front();
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk("busy", i, 64'(busy_o[i]), 64'(m_busy));
      chk("done", i, 64'(done_o[i]), 64'(m_done));
      chk("bcd",  i, 64'(bcd_o[i]),  64'(held[i][39:0]));
      chk("neg",  i, 64'(neg_o[i]),  64'(held[i][40]));
      chk("ovf",  i, 64'(ovf_o[i]),  64'(held[i][41]));
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (m_busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("idle_timeout", 0, 64'(t), 64'(0));
  endtask

  // Issue one request at a negedge; optionally poke start while busy.
  task automatic issue(input logic [W-1:0] b, input bit hv, input exp5_t e, input bit poke);
    wait_idle();
    start      = 1'b1;
    bin        = b;
    hand_valid = hv;
    hand_exp   = e;
    @(negedge clk);
    start      = 1'b0;
    hand_valid = 1'b0;
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      bin   = 16'($urandom);
      @(negedge clk);
      start = 1'b0;
      bin   = 16'($urandom);
    end
  endtask

  task automatic dir(input logic [W-1:0] b, input exp5_t e);
    issue(b, 1'b1, e, 1'b1);
  endtask

  logic [W-1:0] sp [13] = '{16'h0000, 16'h0001, 16'h8000, 16'h7FFF, 16'hFFFF, 16'd9, 16'd10,
                            16'd99, 16'd100, 16'd999, 16'd1000, 16'd9999, 16'd10000};

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    bin        = '0;
    hand_valid = 1'b0;
    hand_exp   = '0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-computed results for every configuration
    dir(16'd1234,  pack5(mk(0,0,40'h01234), mk(0,0,40'h01234), mk(0,0,40'h1234), mk(1,0,40'h234), mk(1,0,40'h234)));
    dir(16'hFB2E,  pack5(mk(0,1,40'h01234), mk(0,0,40'h64302), mk(1,0,40'h4302), mk(1,1,40'h234), mk(1,0,40'h302)));
    dir(16'h8000,  pack5(mk(0,1,40'h32768), mk(0,0,40'h32768), mk(1,0,40'h2768), mk(1,1,40'h768), mk(1,0,40'h768)));
    dir(16'hFFFF,  pack5(mk(0,1,40'h00001), mk(0,0,40'h65535), mk(1,0,40'h5535), mk(0,1,40'h001), mk(1,0,40'h535)));
    dir(16'h0000,  pack5(mk(0,0,40'h0), mk(0,0,40'h0), mk(0,0,40'h0), mk(0,0,40'h0), mk(0,0,40'h0)));
    dir(16'd12345, pack5(mk(0,0,40'h12345), mk(0,0,40'h12345), mk(1,0,40'h2345), mk(1,0,40'h345), mk(1,0,40'h345)));
    dir(16'd9999,  pack5(mk(0,0,40'h09999), mk(0,0,40'h09999), mk(0,0,40'h9999), mk(1,0,40'h999), mk(1,0,40'h999)));
    dir(16'd999,   pack5(mk(0,0,40'h00999), mk(0,0,40'h00999), mk(0,0,40'h0999), mk(0,0,40'h999), mk(0,0,40'h999)));
    dir(16'd1000,  pack5(mk(0,0,40'h01000), mk(0,0,40'h01000), mk(0,0,40'h1000), mk(1,0,40'h000), mk(1,0,40'h000)));
    dir(16'h7FFF,  pack5(mk(0,0,40'h32767), mk(0,0,40'h32767), mk(1,0,40'h2767), mk(1,0,40'h767), mk(1,0,40'h767)));
    dir(16'hFFF6,  pack5(mk(0,1,40'h00010), mk(0,0,40'h65526), mk(1,0,40'h5526), mk(0,1,40'h010), mk(1,0,40'h526)));

    // start held high: back-to-back acceptance, bin changes while busy ignored
    wait_idle();
    start = 1'b1;
    repeat (90) begin
      bin = 16'($urandom);
      @(negedge clk);
    end
    start = 1'b0;

    // Reset three clocks into a conversion: abort, no done pulse
    issue(16'd4321, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    dir(16'd1234,  pack5(mk(0,0,40'h01234), mk(0,0,40'h01234), mk(0,0,40'h1234), mk(1,0,40'h234), mk(1,0,40'h234)));

    // Random and corner values against the reference model
    for (int i = 0; i < 2600; i++) begin
      logic [W-1:0] b;
      b = (i % 13 == 0) ? sp[(i / 13) % 13] : 16'($urandom);
      issue(b, 1'b0, '0, 1'b0);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("pending_results", 0, 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
